// File: rtl/ame_num_divide.sv
// Sequential signed radix-2 restoring divider for the AME numerator path.
// Define AME_DIV_ROUND_EN to round the quotient half away from zero (adds one cycle).
module ame_num_divide #(
  parameter int unsigned COMP_DATA_BITS = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           comp_init_i,
  output logic                           comp_busy_o,
  output logic                           comp_done_o,
  input  logic [1:0][COMP_DATA_BITS-1:0] comp_data_i,
  output logic [COMP_DATA_BITS-1:0]      comp_quot_o,
  output logic [COMP_DATA_BITS-1:0]      comp_rem_o,
  output logic                           comp_dz_o
);

  localparam int unsigned N  = COMP_DATA_BITS;
  localparam int unsigned CW = $clog2(N);

  localparam logic [N:0]   MIN_MAG = (N+1)'(1) << (N - 1);
  localparam logic [N:0]   MAX_MAG = MIN_MAG - (N+1)'(1);
  localparam logic [N-1:0] MIN_VAL = N'(MIN_MAG);
  localparam logic [N-1:0] MAX_VAL = ~MIN_VAL;

`ifdef AME_DIV_ROUND_EN
  typedef enum logic [2:0] {S_IDLE, S_ABS, S_DIV, S_RND, S_FIX} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_ABS, S_DIV, S_FIX} state_e;
`endif

  state_e          state_q;
  logic [N-1:0]    num_q;
  logic [N-1:0]    den_q;
  logic            sn_q;
  logic            sd_q;
  logic            dz_q;
  logic [N:0]      dabs_q;
  logic [N:0]      quo_q;
  logic [N-1:0]    rem_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            dzo_q;
  logic [N-1:0]    quot_o_q;
  logic [N-1:0]    rem_o_q;

  logic [N:0]      rem_sh_d;
  logic            sub_ok_d;
  logic            neg_d;
  logic            sat_d;
  logic [N-1:0]    quot_res_d;
  logic [N-1:0]    rem_res_d;

  // Trial subtraction and signed result formation from the magnitude registers.
  always_comb begin
    rem_sh_d   = {rem_q, quo_q[N-1]};
    sub_ok_d   = (rem_sh_d >= dabs_q);
    neg_d      = sn_q ^ sd_q;
    sat_d      = neg_d ? (quo_q > MIN_MAG) : (quo_q > MAX_MAG);
    quot_res_d = neg_d ? (N'(0) - quo_q[N-1:0]) : quo_q[N-1:0];
    rem_res_d  = sn_q ? (N'(0) - rem_q) : rem_q;
    if (sat_d) begin
      quot_res_d = neg_d ? MIN_VAL : MAX_VAL;
      rem_res_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      den_q    <= '0;
      sn_q     <= 1'b0;
      sd_q     <= 1'b0;
      dz_q     <= 1'b0;
      dabs_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
      quot_o_q <= '0;
      rem_o_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (comp_init_i) begin
            num_q   <= comp_data_i[0];
            den_q   <= comp_data_i[1];
            sn_q    <= comp_data_i[0][N-1];
            sd_q    <= comp_data_i[1][N-1];
            busy_q  <= 1'b1;
            state_q <= S_ABS;
          end
        end
        // Magnitudes carry an extra bit so the most negative value survives negation.
        S_ABS: begin
          quo_q   <= sn_q ? ((N+1)'(0) - {num_q[N-1], num_q}) : {num_q[N-1], num_q};
          dabs_q  <= sd_q ? ((N+1)'(0) - {den_q[N-1], den_q}) : {den_q[N-1], den_q};
          rem_q   <= '0;
          cnt_q   <= CW'(N - 1);
          dz_q    <= (den_q == '0);
          state_q <= (den_q == '0) ? S_FIX : S_DIV;
        end
        S_DIV: begin
          rem_q <= sub_ok_d ? N'(rem_sh_d - dabs_q) : N'(rem_sh_d);
          quo_q <= {1'b0, quo_q[N-2:0], sub_ok_d};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
`ifdef AME_DIV_ROUND_EN
            state_q <= S_RND;
`else
            state_q <= S_FIX;
`endif
          end
        end
`ifdef AME_DIV_ROUND_EN
        S_RND: begin
          if ({rem_q, 1'b0} >= dabs_q) quo_q <= quo_q + (N+1)'(1);
          state_q <= S_FIX;
        end
`endif
        S_FIX: begin
          done_q  <= 1'b1;
          dzo_q   <= dz_q;
          state_q <= S_IDLE;
          if (dz_q) begin
            quot_o_q <= sn_q ? MIN_VAL : MAX_VAL;
            rem_o_q  <= '0;
          end else begin
            quot_o_q <= quot_res_d;
            rem_o_q  <= rem_res_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign comp_busy_o = busy_q;
  assign comp_done_o = done_q;
  assign comp_quot_o = quot_o_q;
  assign comp_rem_o  = rem_o_q;
  assign comp_dz_o   = dzo_q;

endmodule

// File: doc/ame_num_divide.md
Name: ame_num_divide

Overview:
- Sequential signed divider for the AME numerator path.
- Takes the numerator produced by the AME numerator stage (M*D - L*C) and a denominator, and returns the quotient and remainder for affine parameter derivation.
- Sits downstream of the numerator compute unit and uses the same comp_init/comp_done handshake flavour.
- Radix-2 restoring division, one quotient bit per cycle, so a single shared instance serves the AME solver.

Parameters:
- COMP_DATA_BITS, 64, width of numerator, denominator, quotient and remainder (two's complement, minimum 4).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- comp_init_i  input  1  start request; sampled only while idle.
- comp_busy_o  output  1  high from the cycle after acceptance until comp_done_o is asserted, inclusive.
- comp_done_o  output  1  one-cycle pulse; result outputs valid from this cycle.
- comp_data_i  input  [1:0][COMP_DATA_BITS]  {den, num}: [1] = denominator, [0] = numerator; sampled on acceptance only.
- comp_quot_o  output  COMP_DATA_BITS  signed quotient.
- comp_rem_o  output  COMP_DATA_BITS  signed remainder; sign follows the numerator.
- comp_dz_o  output  1  divide-by-zero flag, valid with comp_done_o.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; comp_busy_o, comp_done_o, comp_dz_o = 0; comp_quot_o, comp_rem_o = 0.
  - Applies mid-operation: the operation is abandoned and no comp_done_o is issued.
- Notation: N = COMP_DATA_BITS. "Accepted at edge T" means IDLE and comp_init_i=1 at edge T.
- States:
  - IDLE: wait for comp_init_i. On acceptance, latch num/den, record the signs, go to ABS.
  - ABS (1 cycle): form |num| and |den| in N+1 bits so that -2^(N-1) is representable.
    - den==0: go to FIX.
    - otherwise: clear partial remainder, set counter = N-1, go to DIV.
  - DIV (N cycles): shift the partial remainder left, bringing in the next numerator MSB.
    - Trial-subtract |den|; if non-negative, keep the difference and set quotient bit = 1, else quotient bit = 0.
    - Counter decrements; at 0 go to FIX.
  - FIX (1 cycle): register the signed results and pulse comp_done_o, then go to IDLE.
    - Negate the quotient if the numerator and denominator signs differ; negate the remainder if num<0.
- Latency:
  - Normal: comp_done_o at edge T+N+2.
  - Divide-by-zero: comp_done_o at edge T+2.
  - Back-to-back: a new comp_init_i is accepted on the cycle after comp_done_o (IDLE), giving throughput of 1 result per N+3 cycles.
- comp_init_i while busy (not IDLE): ignored; no queueing.
- Result outputs hold their values until the next comp_done_o or reset. comp_dz_o updates only at comp_done_o.
- Divide-by-zero: comp_dz_o=1; comp_quot_o = 2^(N-1)-1 if num>=0, else -2^(N-1); comp_rem_o=0.
- Overflow (num = -2^(N-1), den = -1): comp_quot_o saturates to 2^(N-1)-1, comp_rem_o=0, comp_dz_o=0.
- Rounding: the quotient truncates toward zero; the remainder satisfies num = quot*den + rem, except in the saturation cases above.

Optional Feature:
- Macro AME_DIV_ROUND_EN.
- Defined:
  - Extra state RND between FIX-sign-compute and output: if 2*|rem| >= |den|, |quot| is incremented before the sign is applied (round half away from zero).
  - Saturation applies if the increment overflows.
  - comp_rem_o remains the truncated remainder.
  - Latency becomes T+N+3 (divide-by-zero stays T+2).
- Undefined: truncation toward zero, latency as above, no RND state.

Test Plan:
- N=64, num=100, den=7, init at T → done at T+66 only; quot=14, rem=2, dz=0, busy high T+1..T+66.
- num=-100, den=7 → quot=-14, rem=-2. num=100, den=-7 → quot=-14, rem=2.
- num=5, den=0 → done at T+2; dz=1, quot=0x7FFF_FFFF_FFFF_FFFF, rem=0. num=-5, den=0 → quot=0x8000_0000_0000_0000.
- num=0x8000_0000_0000_0000, den=-1 → quot=0x7FFF_FFFF_FFFF_FFFF, rem=0, dz=0. num=-2^63, den=1 → quot=-2^63.
- Pulse comp_init_i at T+10 during a busy operation → ignored, exactly one done. Assert rst_i at T+20 → all outputs 0, no done; a new init after reset completes normally.
- With AME_DIV_ROUND_EN: 11/2 → 6 at T+67; -11/2 → -6; 100/7 → 14; without the macro 11/2 → 5.
